// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, forwarding and halt-drain controller
//
// Purpose:
//   Hazard and sequencing control for a 16-bit 5-stage core (IF/ID/EX/MEM/WB).
//   A two-entry scoreboard (EX, MEM) tracks in-flight writers. From it and the
//   decoded ID instruction the block raises stall/flush/bubble/freeze controls,
//   registers the EX-stage forwarding selects, and sequences the halt drain.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid                    ID holds a real instruction
//   id_rs, id_rt                ID source registers
//   id_rs_used, id_rt_used      ID reads the corresponding source
//   id_rd, id_wr_en             ID destination register and its write enable
//   id_is_load, id_halt         ID is a load / is HLT
//   ex_br_taken                 branch resolved taken in EX this cycle
//   mem_busy                    data memory not ready, whole pipeline holds
//   pc_stall, ifid_stall        hold PC / hold IF/ID
//   ifid_flush, idex_bubble     NOP into IF/ID / NOP into ID/EX
//   pipe_freeze                 hold ID/EX, EX/MEM, MEM/WB
//   fwd_a_sel, fwd_b_sel        EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   halted                      core has fully halted
module hazard_ctrl #(
  parameter int REG_AW    = 4,
  parameter int DRAIN_CYC = 3,
  parameter int ZERO_REG  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              id_halt,
  input  logic              ex_br_taken,
  input  logic              mem_busy,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              halted
);

  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              sb_ex_valid_q, sb_ex_valid_d;
  logic [REG_AW-1:0] sb_ex_rd_q, sb_ex_rd_d;
  logic              sb_ex_wr_q, sb_ex_wr_d;
  logic              sb_ex_load_q, sb_ex_load_d;
  logic              sb_mem_valid_q, sb_mem_valid_d;
  logic [REG_AW-1:0] sb_mem_rd_q, sb_mem_rd_d;
  logic              sb_mem_wr_q, sb_mem_wr_d;
  logic              sb_mem_load_q, sb_mem_load_d;

  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;

  function automatic logic match(input logic [REG_AW-1:0] src, input logic used,
                                 input logic v, input logic wr,
                                 input logic [REG_AW-1:0] rd);
    logic zero_blk;
    zero_blk = (ZERO_REG != 0) && (rd == '0);
    return v && wr && used && (rd == src) && !zero_blk;
  endfunction

  logic m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;
  logic load_use, halt_go, squash, enter_ex;

  assign m_ex_rs  = match(id_rs, id_rs_used, sb_ex_valid_q, sb_ex_wr_q, sb_ex_rd_q);
  assign m_ex_rt  = match(id_rt, id_rt_used, sb_ex_valid_q, sb_ex_wr_q, sb_ex_rd_q);
  assign m_mem_rs = match(id_rs, id_rs_used, sb_mem_valid_q, sb_mem_wr_q, sb_mem_rd_q);
  assign m_mem_rt = match(id_rt, id_rt_used, sb_mem_valid_q, sb_mem_wr_q, sb_mem_rd_q);

  assign load_use = id_valid & sb_ex_load_q & (m_ex_rs | m_ex_rt);

  // HLT only commits when it actually leaves ID this cycle.
  assign halt_go  = (state_q == ST_RUN) & id_valid & id_halt &
                    ~mem_busy & ~ex_br_taken & ~load_use;

  // Anything that turns the ID slot into a NOP keeps it out of the scoreboard.
  assign squash   = idex_bubble | ifid_flush;
  assign enter_ex = id_valid & ~squash;

  // FSM: state register (also holds scoreboard and forwarding flops)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      sb_ex_valid_q  <= 1'b0;
      sb_ex_rd_q     <= '0;
      sb_ex_wr_q     <= 1'b0;
      sb_ex_load_q   <= 1'b0;
      sb_mem_valid_q <= 1'b0;
      sb_mem_rd_q    <= '0;
      sb_mem_wr_q    <= 1'b0;
      sb_mem_load_q  <= 1'b0;
      fwd_a_q        <= 2'b00;
      fwd_b_q        <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sb_ex_valid_q  <= sb_ex_valid_d;
      sb_ex_rd_q     <= sb_ex_rd_d;
      sb_ex_wr_q     <= sb_ex_wr_d;
      sb_ex_load_q   <= sb_ex_load_d;
      sb_mem_valid_q <= sb_mem_valid_d;
      sb_mem_rd_q    <= sb_mem_rd_d;
      sb_mem_wr_q    <= sb_mem_wr_d;
      sb_mem_load_q  <= sb_mem_load_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
    end
  end

  // FSM: next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_go) begin
          state_d = ST_DRAIN;
          cnt_d   = CW'(DRAIN_CYC - 1);
        end
      end
      ST_DRAIN: begin
        if (!mem_busy) begin
          if (cnt_q == '0) state_d = ST_HALTED;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Scoreboard shift and registered forwarding selects; both hold on freeze.
  always_comb begin
    sb_ex_valid_d  = sb_ex_valid_q;
    sb_ex_rd_d     = sb_ex_rd_q;
    sb_ex_wr_d     = sb_ex_wr_q;
    sb_ex_load_d   = sb_ex_load_q;
    sb_mem_valid_d = sb_mem_valid_q;
    sb_mem_rd_d    = sb_mem_rd_q;
    sb_mem_wr_d    = sb_mem_wr_q;
    sb_mem_load_d  = sb_mem_load_q;
    fwd_a_d        = fwd_a_q;
    fwd_b_d        = fwd_b_q;
    if (!mem_busy) begin
      sb_mem_valid_d = sb_ex_valid_q;
      sb_mem_rd_d    = sb_ex_rd_q;
      sb_mem_wr_d    = sb_ex_wr_q;
      sb_mem_load_d  = sb_ex_load_q;
      sb_ex_valid_d  = enter_ex;
      sb_ex_rd_d     = id_rd;
      sb_ex_wr_d     = id_wr_en;
      sb_ex_load_d   = id_is_load;
      // EX match is checked first so the youngest producer wins.
      fwd_a_d = !enter_ex ? 2'b00 : m_ex_rs ? 2'b01 : m_mem_rs ? 2'b10 : 2'b00;
      fwd_b_d = !enter_ex ? 2'b00 : m_ex_rt ? 2'b01 : m_mem_rt ? 2'b10 : 2'b00;
    end
  end

  // FSM: outputs. Held at 0 while reset is asserted regardless of inputs.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    halted      = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        pipe_freeze = 1'b1;
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
      end else if (ex_br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
      // Once HLT has left ID, fetch stays shut until reset.
      if (state_q != ST_RUN) begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
      end
      halted = (state_q == ST_HALTED);
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a reference model
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_halt;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       ex_br_taken, mem_busy;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, halted;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(4), .DRAIN_CYC(3), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_halt(id_halt),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: the in-flight instructions in EX and MEM, the forwarding
  // choice made for the instruction now in EX, and the halt progress.
  typedef struct packed {
    logic       v;
    logic [3:0] rd;
    logic       wr;
    logic       ld;
  } ent_t;

  ent_t       m_ex, m_mem;
  logic [1:0] m_fa, m_fb;
  int         m_mode;   // 0 running, 1 draining, 2 halted
  int         m_left;   // non-busy drain cycles still needed

  function automatic bit writes(input logic [3:0] src, input logic used, input ent_t e);
    return e.v && e.wr && used && (e.rd == src) && (e.rd != 4'd0);
  endfunction

  function automatic logic [1:0] source_of(input logic [3:0] src, input logic used);
    if (writes(src, used, m_ex))  return 2'b01;
    if (writes(src, used, m_mem)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_fa = 2'b00; m_fb = 2'b00; m_mode = 0; m_left = 0;
  endtask

  task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                        input logic rsu, input logic rtu, input logic [3:0] rd,
                        input logic wr, input logic ld, input logic hlt);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_rd = rd; id_wr_en = wr; id_is_load = ld; id_halt = hlt;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_br_taken = 0; mem_busy = 0;
  endtask

  // One clock cycle: check every output against the model, then advance both.
  task automatic step();
    bit   lu, e_pc, e_st, e_fl, e_bb, e_fz, kill;
    ent_t n_ex, n_mem;
    logic [1:0] n_fa, n_fb;
    int   n_mode, n_left;
    #1;
    lu = id_valid && m_ex.ld &&
         (writes(id_rs, id_rs_used, m_ex) || writes(id_rt, id_rt_used, m_ex));
    e_pc = 0; e_st = 0; e_fl = 0; e_bb = 0; e_fz = 0;
    if (mem_busy)         begin e_fz = 1; e_pc = 1; e_st = 1; end
    else if (ex_br_taken) begin e_fl = 1; e_bb = 1; end
    else if (lu)          begin e_pc = 1; e_st = 1; e_bb = 1; end
    if (m_mode != 0)      begin e_pc = 1; e_fl = 1; end
    chk("pc_stall",    8'(pc_stall),    8'(e_pc));
    chk("ifid_stall",  8'(ifid_stall),  8'(e_st));
    chk("ifid_flush",  8'(ifid_flush),  8'(e_fl));
    chk("idex_bubble", 8'(idex_bubble), 8'(e_bb));
    chk("pipe_freeze", 8'(pipe_freeze), 8'(e_fz));
    chk("halted",      8'(halted),      8'(m_mode == 2));
    chk("fwd_a_sel",   8'(fwd_a_sel),   8'(m_fa));
    chk("fwd_b_sel",   8'(fwd_b_sel),   8'(m_fb));

    n_ex = m_ex; n_mem = m_mem; n_fa = m_fa; n_fb = m_fb;
    n_mode = m_mode; n_left = m_left;
    if (!mem_busy) begin
      kill  = e_bb || e_fl || !id_valid;
      n_mem = m_ex;
      n_ex  = kill ? ent_t'(0) : ent_t'({1'b1, id_rd, id_wr_en, id_is_load});
      n_fa  = kill ? 2'b00 : source_of(id_rs, id_rs_used);
      n_fb  = kill ? 2'b00 : source_of(id_rt, id_rt_used);
    end
    if (m_mode == 0 && id_valid && id_halt && !mem_busy && !ex_br_taken && !lu) begin
      n_mode = 1; n_left = 3;
    end else if (m_mode == 1 && !mem_busy) begin
      n_left = m_left - 1;
      if (n_left == 0) n_mode = 2;
    end
    @(posedge clk);
    #1;
    m_ex = n_ex; m_mem = n_mem; m_fa = n_fa; m_fb = n_fb;
    m_mode = n_mode; m_left = n_left;
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 0;
    #1;
    chk({tag, "_pc"},   8'(pc_stall),    8'd0);
    chk({tag, "_st"},   8'(ifid_stall),  8'd0);
    chk({tag, "_fl"},   8'(ifid_flush),  8'd0);
    chk({tag, "_bb"},   8'(idex_bubble), 8'd0);
    chk({tag, "_fz"},   8'(pipe_freeze), 8'd0);
    chk({tag, "_hlt"},  8'(halted),      8'd0);
    chk({tag, "_fa"},   8'(fwd_a_sel),   8'd0);
    chk({tag, "_fb"},   8'(fwd_b_sel),   8'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    int rise;
    rst_n = 0;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    mem_busy = 1;
    #1;
    chk("rst_freeze", 8'(pipe_freeze), 8'd0);
    chk("rst_pc",     8'(pc_stall),    8'd0);
    chk("rst_fwd_a",  8'(fwd_a_sel),   8'd0);
    chk("rst_halted", 8'(halted),      8'd0);
    mem_busy = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    step();

    // 1: LD R1 ; ADD R2,R1,R3 -> one-cycle stall, then MEM/WB forward
    set_id(1, 0, 0, 1, 0, 1, 1, 1, 0); step();
    set_id(1, 1, 3, 1, 1, 2, 1, 0, 0);
    #1;
    chk("t1_pc",     8'(pc_stall),    8'd1);
    chk("t1_stall",  8'(ifid_stall),  8'd1);
    chk("t1_bubble", 8'(idex_bubble), 8'd1);
    step();
    #1;
    chk("t1_no_2nd_stall", 8'(pc_stall), 8'd0);
    step();
    chk("t1_fwd_a", 8'(fwd_a_sel), 8'd2);
    chk("t1_fwd_b", 8'(fwd_b_sel), 8'd0);
    idle(); step(); step();

    // 2: ADD R1 ; SUB R4,R1,R1 -> no stall, both operands from EX/MEM
    set_id(1, 2, 3, 1, 1, 1, 1, 0, 0); step();
    set_id(1, 1, 1, 1, 1, 4, 1, 0, 0);
    #1;
    chk("t2_no_stall", 8'(pc_stall), 8'd0);
    step();
    chk("t2_fwd_a", 8'(fwd_a_sel), 8'd1);
    chk("t2_fwd_b", 8'(fwd_b_sel), 8'd1);
    idle(); step(); step();

    // 3: ADD R1 ; ADD R1 ; OR R5,R1,R6 -> youngest producer wins
    set_id(1, 2, 3, 1, 1, 1, 1, 0, 0); step();
    set_id(1, 2, 3, 1, 1, 1, 1, 0, 0); step();
    set_id(1, 1, 6, 1, 1, 5, 1, 0, 0); step();
    chk("t3_fwd_a", 8'(fwd_a_sel), 8'd1);
    chk("t3_fwd_b", 8'(fwd_b_sel), 8'd0);
    // R0 destination never forwards
    set_id(1, 2, 3, 1, 1, 0, 1, 0, 0); step();
    set_id(1, 0, 0, 1, 1, 5, 1, 0, 0); step();
    chk("t3_r0_fwd", 8'(fwd_a_sel), 8'd0);
    idle(); step(); step();

    // 4: taken branch squashes HLT in ID
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    ex_br_taken = 1;
    #1;
    chk("t4_flush",  8'(ifid_flush),  8'd1);
    chk("t4_bubble", 8'(idex_bubble), 8'd1);
    step();
    idle();
    #1;
    chk("t4_still_run", 8'(pc_stall), 8'd0);
    step();
    chk("t4_halted", 8'(halted), 8'd0);

    // 5: HLT, then mem_busy for 2 cycles during drain -> halted 5 edges later
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
    idle();
    rise = -1;
    for (int e = 1; e <= 12; e++) begin
      mem_busy = (e == 2 || e == 3);
      step();
      if (halted === 1'b1 && rise < 0) rise = e;
    end
    chk("t5_halt_delay", 8'(rise), 8'd5);
    idle();
    do_reset("t5_rst");
    step();

    // 6: mem_busy with branch and load-use -> only freeze/stalls; then reset mid-drain
    set_id(1, 0, 0, 0, 0, 1, 1, 1, 0); step();
    set_id(1, 1, 0, 1, 0, 2, 1, 0, 0);
    ex_br_taken = 1; mem_busy = 1;
    #1;
    chk("t6_freeze", 8'(pipe_freeze), 8'd1);
    chk("t6_pc",     8'(pc_stall),    8'd1);
    chk("t6_stall",  8'(ifid_stall),  8'd1);
    chk("t6_flush",  8'(ifid_flush),  8'd0);
    chk("t6_bubble", 8'(idex_bubble), 8'd0);
    step();
    mem_busy = 0;
    #1;
    chk("t6_br_reseen", 8'(ifid_flush), 8'd1);
    step();
    idle();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
    idle(); step();
    chk("t6_draining", 8'(pc_stall), 8'd1);
    do_reset("t6_rst");
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_id($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
             $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
      ex_br_taken = $urandom_range(0, 7) == 0;
      mem_busy    = $urandom_range(0, 5) == 0;
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) ||
          (m_mode == 1 && $urandom_range(0, 9) == 0))
        do_reset("rnd_rst");
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
